_6bit_seq_multiplier: RTL and testbench



---
 rtl/_6bit_seq_multiplier_pkg.sv | 24 ++
 rtl/_6bit_seq_multiplier_ctrl.sv | 71 +++++++
 rtl/_6bit_twos_neg.sv | 11 +
 rtl/_6bit_seq_multiplier.sv | 90 +++++++++
 tb/tb__6bit_seq_multiplier.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/_6bit_seq_multiplier_pkg.sv
// Shared constants and types for the 6-bit sequential signed multiplier.
//   WIDTH / ITER : operand width and shift-add iteration count (fixed at 6)
//   PW           : product width (2*WIDTH)
//   MIN6 / MAX6  : signed 6-bit range used for the overflow flag
//   state_t      : controller state encoding
package _6bit_seq_multiplier_pkg;

  localparam int WIDTH = 6;
  localparam int ITER  = WIDTH;
  localparam int PW    = 2 * WIDTH;
  localparam int CW    = 3;

  localparam int MIN6 = -32;
  localparam int MAX6 = 31;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_RUN  = 3'd2,
    S_SIGN = 3'd3,
    S_DONE = 3'd4
  } state_t;

endpackage

// File: rtl/_6bit_seq_multiplier_ctrl.sv
// Sequencing controller for the shift-add multiplier: FSM, iteration
// counter and registered busy/done.
//   clk, reset_n : clock, asynchronous active-low reset
//   start        : launch request, honoured only in S_IDLE
//   state        : current state, consumed by the datapath
//   cnt          : iteration index during S_RUN (0..ITER-1)
//   busy         : high in LOAD, RUN, SIGN, DONE
//   done         : high only in DONE
//
// state  | meaning
// S_IDLE | waiting for start; operands latched on accept
// S_LOAD | derive magnitudes and sign, clear accumulator/counter
// S_RUN  | one shift-add step per cycle, ITER cycles
// S_SIGN | apply sign to magnitude product, compute ovf
// S_DONE | one-cycle done pulse, result valid
module _mult_ctrl
  import _6bit_seq_multiplier_pkg::*;
(
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  output state_t        state,
  output logic [CW-1:0] cnt,
  output logic          busy,
  output logic          done
);

  localparam logic [CW-1:0] CNT_LAST = CW'(ITER - 1);

  // busy/done are set on the edge entering their state so they line up
  // exactly with the state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_LOAD;
            busy  <= 1'b1;
          end
        end
        S_LOAD: begin
          cnt   <= '0;
          state <= S_RUN;
        end
        S_RUN: begin
          cnt <= cnt + CW'(1);
          if (cnt == CNT_LAST) state <= S_SIGN;
        end
        S_SIGN: begin
          state <= S_DONE;
          done  <= 1'b1;
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/_6bit_twos_neg.sv
// 6-bit two's-complement negation stage (combinational).
//   a : input operand
//   y : -a, modulo 2^6 (-32 maps to itself, i.e. unsigned 32)
module _6bit_twos_neg (
  input  logic [5:0] a,
  output logic [5:0] y
);

  assign y = ~a + 6'd1;

endmodule

// File: rtl/_6bit_seq_multiplier.sv
// Sequential signed 6x6 shift-add multiplier.
//   clk, reset_n : clock, asynchronous active-low reset
//   start        : launch request (ignored while busy)
//   x, y         : signed two's-complement operands, latched on accept
//   busy         : operation in progress (LOAD..DONE)
//   done         : one-cycle pulse, product/ovf valid
//   product      : signed 12-bit product, held until the next accept
//   ovf          : product outside -32..31, held with product
module _6bit_seq_multiplier
  import _6bit_seq_multiplier_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic [PW-1:0]    product,
  output logic             ovf
);

  state_t          state;
  logic [CW-1:0]   cnt;

  logic [WIDTH-1:0] x_lat, y_lat;
  logic [WIDTH-1:0] x_neg, y_neg;
  logic [WIDTH-1:0] mag_x, mult;
  logic [PW-1:0]    acc;
  logic             neg;

  logic signed [PW-1:0] prod_nxt;
  logic                 ovf_nxt;

  _mult_ctrl u_ctrl (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .state   (state),
    .cnt     (cnt),
    .busy    (busy),
    .done    (done)
  );

  _6bit_twos_neg u_neg_x (.a(x_lat), .y(x_neg));
  _6bit_twos_neg u_neg_y (.a(y_lat), .y(y_neg));

  // A zero accumulator negates back to zero, so no negative-zero case.
  assign prod_nxt = neg ? PW'(~acc + PW'(1)) : acc;
  assign ovf_nxt  = (prod_nxt < MIN6) || (prod_nxt > MAX6);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_lat   <= '0;
      y_lat   <= '0;
      mag_x   <= '0;
      mult    <= '0;
      acc     <= '0;
      neg     <= 1'b0;
      product <= '0;
      ovf     <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            x_lat <= x;
            y_lat <= y;
          end
        end
        S_LOAD: begin
          // -32 negates to 6'b100000, which is the correct unsigned magnitude.
          mag_x <= x_lat[WIDTH-1] ? x_neg : x_lat;
          mult  <= y_lat[WIDTH-1] ? y_neg : y_lat;
          neg   <= x_lat[WIDTH-1] ^ y_lat[WIDTH-1];
          acc   <= '0;
        end
        S_RUN: begin
          if (mult[0]) acc <= acc + (PW'(mag_x) << cnt);
          mult <= mult >> 1;
        end
        S_SIGN: begin
          product <= prod_nxt;
          ovf     <= ovf_nxt;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb__6bit_seq_multiplier.sv
module tb__6bit_seq_multiplier;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [5:0]  x = '0;
  logic [5:0]  y = '0;
  logic        busy, done, ovf;
  logic [11:0] product;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  _6bit_seq_multiplier dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .x       (x),
    .y       (y),
    .busy    (busy),
    .done    (done),
    .product (product),
    .ovf     (ovf)
  );

  typedef struct {
    logic [5:0]  x;
    logic [5:0]  y;
    logic [11:0] p;
    logic        ovf;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Drives start for one accept edge, then scrambles x/y to prove latching.
  task automatic launch(input logic [5:0] a, input logic [5:0] b);
    @(negedge clk);
    x = a;
    y = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    x = ~a;
    y = ~b;
  endtask

  task automatic wait_done(output int k, output logic busy_ok);
    k = 0;
    busy_ok = 1'b1;
    do begin
      @(posedge clk);
      #1;
      k++;
      if (!busy) busy_ok = 1'b0;
    end while (!done && k < 20);
  endtask

  task automatic run_vec(input string name, input vec_t v);
    int   k;
    logic bok;
    launch(v.x, v.y);
    check({name, ".busy_load"}, busy, 1);
    wait_done(k, bok);
    check({name, ".done"}, done, 1);
    check({name, ".latency"}, k, 8);
    check({name, ".busy"}, bok, 1);
    check({name, ".product"}, product, v.p);
    check({name, ".ovf"}, ovf, v.ovf);
    @(posedge clk);
    #1;
    check({name, ".done_pulse"}, done, 0);
    check({name, ".busy_idle"}, busy, 0);
    check({name, ".product_hold"}, product, v.p);
  endtask

  initial begin
    int   k;
    logic bok;
    logic saw_done;

    vecs[0]  = '{6'h05, 6'h03, 12'h00F, 1'b0};  //   5 *   3 =   15
    vecs[1]  = '{6'h39, 6'h06, 12'hFD6, 1'b1};  //  -7 *   6 =  -42
    vecs[2]  = '{6'h20, 6'h20, 12'h400, 1'b1};  // -32 * -32 = 1024
    vecs[3]  = '{6'h20, 6'h01, 12'hFE0, 1'b0};  // -32 *   1 =  -32
    vecs[4]  = '{6'h00, 6'h2F, 12'h000, 1'b0};  //   0 * -17 =    0
    vecs[5]  = '{6'h3F, 6'h3F, 12'h001, 1'b0};  //  -1 *  -1 =    1
    vecs[6]  = '{6'h1F, 6'h1F, 12'h3C1, 1'b1};  //  31 *  31 =  961
    vecs[7]  = '{6'h1F, 6'h3F, 12'hFE1, 1'b0};  //  31 *  -1 =  -31
    vecs[8]  = '{6'h04, 6'h08, 12'h020, 1'b1};  //   4 *   8 =   32
    vecs[9]  = '{6'h3C, 6'h08, 12'hFE0, 1'b0};  //  -4 *   8 =  -32
    vecs[10] = '{6'h01, 6'h1F, 12'h01F, 1'b0};  //   1 *  31 =   31

    repeat (3) @(posedge clk);
    #1;
    check("reset.busy", busy, 0);
    check("reset.done", done, 0);
    check("reset.product", product, 0);
    check("reset.ovf", ovf, 0);
    @(negedge clk);
    reset_n = 1'b1;

    foreach (vecs[i]) run_vec($sformatf("vec%0d", i), vecs[i]);

    // start pulsed 3 cycles into RUN must be ignored
    launch(6'h05, 6'h03);
    repeat (4) @(posedge clk);
    launch(6'h07, 6'h07);
    wait_done(k, bok);
    check("ignore.done", done, 1);
    check("ignore.latency", k + 5, 8);
    check("ignore.product", product, 12'h00F);
    check("ignore.ovf", ovf, 0);

    // start raised during DONE and held across the next edge
    @(negedge clk);
    x = 6'h39;
    y = 6'h06;
    start = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    start = 1'b0;
    x = 6'h00;
    y = 6'h00;
    wait_done(k, bok);
    check("back2back.done", done, 1);
    check("back2back.product", product, 12'hFD6);
    check("back2back.ovf", ovf, 1);
    @(posedge clk);
    #1;

    // asynchronous reset in the middle of RUN
    launch(6'h1F, 6'h1F);
    repeat (3) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("midreset.busy", busy, 0);
    check("midreset.done", done, 0);
    check("midreset.product", product, 0);
    check("midreset.ovf", ovf, 0);
    saw_done = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
      if (k == 0) reset_n = 1'b1;
      k = 0;
    end
    check("midreset.no_done", saw_done, 0);
    check("midreset.idle", busy, 0);

    run_vec("after_reset", '{6'h3F, 6'h3F, 12'h001, 1'b0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
